// File: rtl/pkt_pkg.sv
// Shared types and constants for the word-to-UART packetizer.
package pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam logic [7:0]  DEFAULT_HEADER     = 8'hA5;
  // Packet position index: header, up to 8 data bytes, optional trailer.
  localparam int unsigned IDX_W              = 4;

  function automatic int unsigned bytes_per_word(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/byte_mux.sv
// Selects byte sel of a word, byte 0 being the most significant.
module byte_mux
  import pkt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [IDX_W-1:0]      sel,
  output logic [7:0]            byte_c
);

  localparam int unsigned NB = bytes_per_word(DATA_WIDTH);

  always_comb begin
    byte_c = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (sel == IDX_W'(i)) byte_c = word[(NB-1-i)*8 +: 8];
    end
  end

endmodule

// File: rtl/word_uart_packetizer.sv
// Pops FIFO words and sends each as HEADER + data bytes (MSB first) to a UART.
// Define PKT_CHECKSUM_EN to append an XOR trailer byte to every packet.
module word_uart_packetizer
  import pkt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter logic [7:0]  HEADER     = DEFAULT_HEADER
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rd_empty,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_rd_inc,
  input  logic                  i_sig_comp,
  output logic [7:0]            o_txbyte,
  output logic                  o_txsend,
  input  logic                  i_txactive,
  input  logic                  i_txdone,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [15:0]           o_word_cnt
);

  localparam int unsigned NB = bytes_per_word(DATA_WIDTH);
`ifdef PKT_CHECKSUM_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB + 1);
`else
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB);
`endif

  state_t                state;
  logic [DATA_WIDTH-1:0] word_q;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      data_sel;
  logic [7:0]            mux_byte_c;
  logic [7:0]            cur_byte_c;
`ifdef PKT_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  // idx 0 is the header, so data byte n sits at idx n+1
  assign data_sel = IDX_W'(idx - IDX_W'(1));

  byte_mux #(.DATA_WIDTH(DATA_WIDTH)) u_byte_mux (
    .word   (word_q),
    .sel    (data_sel),
    .byte_c (mux_byte_c)
  );

  always_comb begin
    cur_byte_c = mux_byte_c;
    if (idx == '0) cur_byte_c = HEADER;
`ifdef PKT_CHECKSUM_EN
    else if (idx == LAST_IDX) cur_byte_c = csum_q;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      word_q     <= '0;
      idx        <= '0;
      o_rd_inc   <= 1'b0;
      o_txsend   <= 1'b0;
      o_txbyte   <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_word_cnt <= '0;
`ifdef PKT_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      o_rd_inc <= 1'b0;
      o_txsend <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!i_rd_empty) begin
            state    <= ST_FETCH;
            o_rd_inc <= 1'b1;
            o_busy   <= 1'b1;
          end else if (i_sig_comp) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
          end
        end
        // Head word is still valid this cycle; the pop takes effect at its end.
        ST_FETCH: begin
          word_q <= i_rd_data;
          idx    <= '0;
          state  <= ST_SEND;
`ifdef PKT_CHECKSUM_EN
          csum_q <= '0;
`endif
        end
        ST_SEND: begin
          if (!i_txactive) begin
            o_txbyte <= cur_byte_c;
            o_txsend <= 1'b1;
            state    <= ST_WAIT;
`ifdef PKT_CHECKSUM_EN
            csum_q   <= csum_q ^ cur_byte_c;
`endif
          end
        end
        ST_WAIT: begin
          if (i_txdone) begin
            if (idx == LAST_IDX) begin
              o_word_cnt <= o_word_cnt + 16'd1;
              o_busy     <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= ST_SEND;
            end
          end
        end
        ST_DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
